mmd_ratio_counter: RTL and testbench
====================================

Name: mmd_ratio_counter

Overview:
- Consumer end of the MASH output interface: reads the per-period 8-bit division ratio (integer plus MASH fractional offset) and runs the programmable multi-modulus divider counter.
- Emits the divided-clock pulse/square wave that clocks the MASH and PFD path.
- Issues a per-period ratio request; the MASH side answers with ratio/valid.
- Accumulates ratios over a window so the average can be checked against int + frac.

Parameters:
- W, 8, ratio width (matches MASH output word).
- MIN_DIV, 4, smallest ratio the divider accepts; smaller values are clamped.
- DEF_RATIO, 16, ratio loaded at reset.
- WIN_LOG2, 4, averaging window of 2^WIN_LOG2 periods.

Ports:
- i_clk  in  1  high-speed (VCO-side) clock.
- i_rst_n  in  1  synchronous reset, active low.
- i_en  in  1  divider run enable.
- i_ratio  in  W  ratio from the MASH output stage.
- i_ratio_valid  in  1  i_ratio is valid this cycle.
- i_clr_flags  in  1  clears sticky flags.
- o_ratio_req  out  1  one-cycle request for the next ratio.
- o_div_pulse  out  1  one-cycle pulse at each period start.
- o_div_clk  out  1  divided clock, high for the first ceil(N/2) cycles of each period.
- o_sum  out  W+WIN_LOG2  sum of ratios over the last window.
- o_sum_valid  out  1  one-cycle strobe when o_sum updates.
- o_underrun  out  1  sticky: a period began without a fresh ratio.
- o_clamp  out  1  sticky: a ratio below MIN_DIV was clamped.

Behaviour:
- Reset (i_rst_n=0 at an edge):
  - State is IDLE. cur_ratio=DEF_RATIO, cnt=0.
  - pend_vld=0, req_out=0.
  - Accumulator and window counter are 0.
  - All outputs are 0.
  - Reset overrides everything, including in mid-period.
- All outputs are registered.
- FSM IDLE:
  - Outputs are low.
  - i_en=1 at edge t goes to RUN and starts a period using cur_ratio (or the captured pending ratio, same rules as a terminal count).
  - cnt<=N-1, and o_div_pulse, o_ratio_req, o_div_clk go high at t+1.
- FSM RUN:
  - If cnt!=0: cnt<=cnt-1.
  - If cnt==0 (terminal): a new period starts. cnt<=N'-1, o_div_pulse=1 and o_ratio_req=1 for the next cycle, and cur_ratio<=N'. Pulse spacing is exactly N cycles.
- RUN with i_en=0 at an edge:
  - Go to IDLE immediately and force outputs low.
  - Clear req_out, pend_vld, accumulator and window counter.
  - Keep cur_ratio and the sticky flags.
- Next ratio N' (selected at the terminal count):
  - If i_ratio_valid is high in the terminal cycle with req_out=1, use i_ratio (bypass).
  - Otherwise, if pend_vld=1, use the pending ratio.
  - Otherwise keep cur_ratio and set o_underrun.
  - pend_vld clears at the terminal count.
- Handshake:
  - req_out sets with o_ratio_req.
  - The first i_ratio_valid while req_out=1 captures i_ratio into pending, sets pend_vld and clears req_out.
  - i_ratio_valid with req_out=0 is ignored (no state change).
- Clamp: any captured ratio < MIN_DIV becomes MIN_DIV and sets o_clamp. Ratio 0 is clamped the same way.
- o_div_clk: high while the period-relative cycle index is < ceil(N/2).
  - N=5: 3 high, 2 low.
  - N=4: 2 high, 2 low.
- Window:
  - At each period start, the accumulator adds N' and the window counter increments.
  - When the 2^WIN_LOG2-th period starts: o_sum <= acc + N', o_sum_valid=1 for one cycle, acc<=0, and the window counter wraps to 0.
  - The accumulator width W+WIN_LOG2 never overflows.
- Sticky flags: clear on i_clr_flags. A set event in the same cycle wins over the clear.

Decomposition:
- Package mmd_pkg:
  - State enum {IDLE, RUN}.
  - Default constants MIN_DIV, DEF_RATIO, WIN_LOG2.
  - Function for clamp and ceil-half.
- One natural sub-module, mmd_ratio_window: the window accumulator with sum/valid strobe. The FSM, counter and handshake stay in the top module.

Test Plan:
- Reset, then i_en=1 with no ratios → o_div_pulse every 16 cycles. o_underrun=1 after the second pulse (the first period uses DEF_RATIO and already sets underrun at its terminal). o_div_clk 8 high / 8 low.
- Answer every o_ratio_req 2 cycles later with i_ratio=10 → pulses spaced 16 then 10,10,…; o_underrun stays 0 after i_clr_flags.
- Alternate ratios 9,10 (mean 9.5) with WIN_LOG2=4 → o_sum_valid every 16 periods with o_sum=152; o_div_clk for N=9 is 5 high / 4 low.
- i_ratio=2 → period 4 cycles, o_clamp=1. Valid delivered exactly in the terminal cycle → bypass: the new ratio takes effect in the very next period.
- Extra i_ratio_valid with no request outstanding → ignored, period unchanged. i_en dropped mid-period → outputs low next cycle. Re-enable → first pulse one cycle later using the last cur_ratio.
- Assert i_rst_n=0 mid-period with ratio 10 loaded → all outputs 0 next cycle. After release and i_en=1, period is 16 (DEF_RATIO).

Source files
------------

// File: rtl/mmd_pkg.sv
// Shared types, default parameters and helper arithmetic for the multi-modulus divider.
package mmd_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned MMD_W         = 8;
  localparam int unsigned MMD_MIN_DIV   = 4;
  localparam int unsigned MMD_DEF_RATIO = 16;
  localparam int unsigned MMD_WIN_LOG2  = 4;

  function automatic logic [31:0] clamp_ratio(input logic [31:0] ratio,
                                              input logic [31:0] min_div);
    return (ratio < min_div) ? min_div : ratio;
  endfunction

  function automatic logic [31:0] ceil_half(input logic [31:0] n);
    return (n >> 1) + {31'd0, n[0]};
  endfunction

endpackage

// File: rtl/mmd_ratio_window.sv
// Sums period ratios over 2^WIN_LOG2 periods and strobes the total for one cycle.
module mmd_ratio_window
  import mmd_pkg::*;
#(
  parameter int unsigned W        = MMD_W,
  parameter int unsigned WIN_LOG2 = MMD_WIN_LOG2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clear,
  input  logic                  i_add,
  input  logic [W-1:0]          i_ratio,
  output logic [W+WIN_LOG2-1:0] o_sum,
  output logic                  o_sum_valid
);

  localparam int unsigned SW = W + WIN_LOG2;

  logic [SW-1:0]       r_acc;
  logic [WIN_LOG2-1:0] r_win_cnt;
  logic [SW-1:0]       r_sum;
  logic                r_sum_valid;
  logic [SW-1:0]       w_acc_nxt;
  logic                w_last;

  assign w_acc_nxt = r_acc + SW'(i_ratio);
  assign w_last    = (r_win_cnt == '1);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      r_acc       <= '0;
      r_win_cnt   <= '0;
      r_sum       <= '0;
      r_sum_valid <= 1'b0;
    end else begin
      r_sum_valid <= 1'b0;
      if (i_add) begin
        if (w_last) begin
          r_sum       <= w_acc_nxt;
          r_sum_valid <= 1'b1;
          r_acc       <= '0;
          r_win_cnt   <= '0;
        end else begin
          r_acc     <= w_acc_nxt;
          r_win_cnt <= r_win_cnt + WIN_LOG2'(1);
        end
      end
    end
  end

  assign o_sum       = r_sum;
  assign o_sum_valid = r_sum_valid;

endmodule

// File: rtl/mmd_ratio_counter.sv
// Multi-modulus divider counter fed per period by the MASH ratio handshake,
// producing the divided pulse/clock and a windowed ratio sum.
module mmd_ratio_counter
  import mmd_pkg::*;
#(
  parameter int unsigned W         = MMD_W,
  parameter int unsigned MIN_DIV   = MMD_MIN_DIV,
  parameter int unsigned DEF_RATIO = MMD_DEF_RATIO,
  parameter int unsigned WIN_LOG2  = MMD_WIN_LOG2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic [W-1:0]          i_ratio,
  input  logic                  i_ratio_valid,
  input  logic                  i_clr_flags,
  output logic                  o_ratio_req,
  output logic                  o_div_pulse,
  output logic                  o_div_clk,
  output logic [W+WIN_LOG2-1:0] o_sum,
  output logic                  o_sum_valid,
  output logic                  o_underrun,
  output logic                  o_clamp
);

  state_e       r_state;
  state_e       w_state_nxt;
  logic [W-1:0] r_cur_ratio;
  logic [W-1:0] r_cnt;
  logic [W-1:0] r_pend_ratio;
  logic         r_pend_vld;
  logic         r_req_out;
  logic         r_div_pulse;
  logic         r_ratio_req;
  logic         r_div_clk;
  logic         r_underrun;
  logic         r_clamp;

  logic [W-1:0] w_cap_ratio;
  logic         w_cap_small;
  logic         w_take;
  logic         w_start;
  logic [W-1:0] w_next_ratio;
  logic [W-1:0] w_ratio_eff;
  logic [W-1:0] w_cnt_nxt;
  logic         w_set_underrun;
  logic         w_set_clamp;
  logic         w_div_clk_nxt;

  assign w_cap_ratio = W'(clamp_ratio(32'(i_ratio), 32'(MIN_DIV)));
  assign w_cap_small = (32'(i_ratio) < 32'(MIN_DIV));
  // A ratio is only accepted while a request is outstanding and the divider keeps running.
  assign w_take      = i_ratio_valid & r_req_out & i_en & (r_state == RUN);
  assign w_set_clamp = w_take & w_cap_small;

  always_comb begin
    w_state_nxt    = r_state;
    w_start        = 1'b0;
    w_next_ratio   = r_cur_ratio;
    w_set_underrun = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_en) begin
          w_state_nxt = RUN;
          w_start     = 1'b1;
        end
      end
      RUN: begin
        if (!i_en) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == '0) begin
          w_start = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_start) begin
      if (w_take) begin
        w_next_ratio = w_cap_ratio;
      end else if (r_pend_vld) begin
        w_next_ratio = r_pend_ratio;
      end else begin
        w_set_underrun = (r_state == RUN);
      end
    end

    w_ratio_eff = w_start ? w_next_ratio : r_cur_ratio;
    w_cnt_nxt   = w_start ? (w_next_ratio - W'(1)) : (r_cnt - W'(1));
    // Period index counts up as cnt counts down: index = N-1-cnt.
    w_div_clk_nxt = (w_state_nxt == RUN) &&
                    ((32'(w_ratio_eff) - 32'(w_cnt_nxt) - 32'd1) < ceil_half(32'(w_ratio_eff)));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_cur_ratio  <= W'(DEF_RATIO);
      r_cnt        <= '0;
      r_pend_ratio <= '0;
      r_pend_vld   <= 1'b0;
      r_req_out    <= 1'b0;
      r_div_pulse  <= 1'b0;
      r_ratio_req  <= 1'b0;
      r_div_clk    <= 1'b0;
      r_underrun   <= 1'b0;
      r_clamp      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_div_pulse <= w_start;
      r_ratio_req <= w_start;
      r_div_clk   <= w_div_clk_nxt;
      if (w_start) begin
        r_cnt       <= w_cnt_nxt;
        r_cur_ratio <= w_next_ratio;
        r_req_out   <= 1'b1;
        r_pend_vld  <= 1'b0;
      end else if (w_state_nxt == RUN) begin
        r_cnt <= w_cnt_nxt;
        if (w_take) begin
          r_pend_ratio <= w_cap_ratio;
          r_pend_vld   <= 1'b1;
          r_req_out    <= 1'b0;
        end
      end else begin
        r_cnt      <= '0;
        r_req_out  <= 1'b0;
        r_pend_vld <= 1'b0;
      end
      r_underrun <= w_set_underrun | (r_underrun & ~i_clr_flags);
      r_clamp    <= w_set_clamp | (r_clamp & ~i_clr_flags);
    end
  end

  mmd_ratio_window #(
    .W        (W),
    .WIN_LOG2 (WIN_LOG2)
  ) u_window (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clear     (~i_en),
    .i_add       (w_start),
    .i_ratio     (w_next_ratio),
    .o_sum       (o_sum),
    .o_sum_valid (o_sum_valid)
  );

  assign o_ratio_req = r_ratio_req;
  assign o_div_pulse = r_div_pulse;
  assign o_div_clk   = r_div_clk;
  assign o_underrun  = r_underrun;
  assign o_clamp     = r_clamp;

endmodule

// File: tb/tb_mmd_ratio_counter.sv
// Randomized and directed bench for mmd_ratio_counter against a period-level reference model.
module tb_mmd_ratio_counter;

  localparam int MIN = 4;
  localparam int DEF = 16;
  localparam int WIN = 16;

  logic        clk = 1'b0;
  logic        rst_n, en, vld, clr;
  logic [7:0]  ratio;
  logic        o_ratio_req, o_div_pulse, o_div_clk, o_sum_valid, o_underrun, o_clamp;
  logic [11:0] o_sum;

  always #5 clk = ~clk;

  mmd_ratio_counter dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_en          (en),
    .i_ratio       (ratio),
    .i_ratio_valid (vld),
    .i_clr_flags   (clr),
    .o_ratio_req   (o_ratio_req),
    .o_div_pulse   (o_div_pulse),
    .o_div_clk     (o_div_clk),
    .o_sum         (o_sum),
    .o_sum_valid   (o_sum_valid),
    .o_underrun    (o_underrun),
    .o_clamp       (o_clamp)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: position counts up within a period of length m_n.
  bit m_run = 0, m_req_out = 0, m_have_pend = 0;
  int m_pos = 0, m_n = DEF, m_cur = DEF, m_pend = 0;
  int win_k = 0, win_acc = 0;
  bit e_pulse = 0, e_req = 0, e_clk = 0, e_und = 0, e_clamp = 0, e_sv = 0;
  int e_sum = 0;

  task automatic model_step(input bit r, input bit e, input bit v, input int rt, input bit c);
    bit start = 0;
    bit su = 0;
    bit sc = 0;
    int nxt;
    int cap;
    cap = (rt < MIN) ? MIN : rt;
    if (!r) begin
      m_run = 0; m_req_out = 0; m_have_pend = 0; m_pos = 0; m_n = DEF; m_cur = DEF;
      win_k = 0; win_acc = 0;
      e_pulse = 0; e_req = 0; e_clk = 0; e_und = 0; e_clamp = 0; e_sv = 0;
      return;
    end
    e_pulse = 0; e_req = 0; e_sv = 0; e_clk = 0;
    if (m_run && !e) begin
      m_run = 0; m_req_out = 0; m_have_pend = 0; win_k = 0; win_acc = 0;
    end else if (e) begin
      if (!m_run || m_pos == m_n - 1) start = 1;
      else m_pos++;
      if (start) begin
        if (v && m_req_out) begin nxt = cap; sc = (rt < MIN); end
        else if (m_have_pend) nxt = m_pend;
        else begin nxt = m_cur; su = m_run; end
        m_run = 1; m_cur = nxt; m_n = nxt; m_pos = 0;
        m_req_out = 1; m_have_pend = 0; e_pulse = 1; e_req = 1;
        win_acc += nxt; win_k++;
        if (win_k == WIN) begin e_sv = 1; e_sum = win_acc; win_acc = 0; win_k = 0; end
      end else if (v && m_req_out) begin
        m_pend = cap; sc = (rt < MIN); m_have_pend = 1; m_req_out = 0;
      end
      e_clk = (m_pos < (m_n + 1) / 2);
    end
    e_und   = su | (e_und & !c);
    e_clamp = sc | (e_clamp & !c);
  endtask

  // Responder: answers each request after ans_delay cycles (1 = same cycle as the request).
  int ans_mode = 0, ans_delay = 2, ans_val = 10, ans_cnt = 0;
  bit alt = 0;
  int spur_pct = 0, clr_pct = 0;
  int cyc = 0, last_pulse = 0, last_gap = 0, last_sum = 0;

  task automatic step();
    bit r, e, v, c;
    int rt;
    r = rst_n; e = en; v = vld; c = clr; rt = ratio;
    @(posedge clk);
    #1;
    cyc++;
    model_step(r, e, v, rt, c);
    check("div_pulse", o_div_pulse, e_pulse);
    check("ratio_req", o_ratio_req, e_req);
    check("div_clk", o_div_clk, e_clk);
    check("underrun", o_underrun, e_und);
    check("clamp", o_clamp, e_clamp);
    check("sum_valid", o_sum_valid, e_sv);
    if (e_sv) check("sum", o_sum, e_sum);
    if (o_div_pulse) begin last_gap = cyc - last_pulse; last_pulse = cyc; end
    if (o_sum_valid) last_sum = o_sum;
    vld = 0; clr = 0; ratio = 8'($urandom_range(0, 255));
    if (o_ratio_req && ans_mode != 0) ans_cnt = ans_delay;
    if (ans_cnt > 0) begin
      ans_cnt--;
      if (ans_cnt == 0) begin
        vld = 1;
        case (ans_mode)
          2: begin ratio = alt ? 8'd10 : 8'd9; alt = ~alt; end
          3: ratio = 8'($urandom_range(0, 20));
          default: ratio = 8'(ans_val);
        endcase
      end
    end else if (int'($urandom_range(0, 99)) < spur_pct) begin
      vld = 1; ratio = 8'($urandom_range(0, 20));
    end
    if (int'($urandom_range(0, 99)) < clr_pct) clr = 1;
  endtask

  task automatic wait_pulse();
    int n = 0;
    do begin step(); n++; end while (!o_div_pulse && n < 300);
    if (!o_div_pulse) check("pulse_timeout", 0, 1);
  endtask

  initial begin
    rst_n = 0; en = 0; vld = 0; clr = 0; ratio = 0;
    step(); step();
    check("rst_sum", o_sum, 0);
    check("rst_clk", o_div_clk, 0);
    rst_n = 1;
    step();

    // Free-running on the reset ratio, no answers.
    en = 1;
    repeat (50) step();
    check("gap_default", last_gap, 16);
    check("underrun_default", o_underrun, 1);

    // Answer every request with 10 two cycles later, then clear flags.
    ans_mode = 1; ans_val = 10; ans_delay = 2;
    repeat (40) step();
    clr = 1;
    step();
    repeat (40) step();
    check("gap_ten", last_gap, 10);
    check("underrun_cleared", o_underrun, 0);

    // Alternating 9/10 averages 9.5 over a window of 16.
    ans_mode = 2;
    repeat (600) step();
    check("sum_alt", last_sum, 152);

    // Ratio below minimum clamps to 4.
    ans_mode = 1; ans_val = 2; ans_delay = 2;
    repeat (40) step();
    check("gap_clamp", last_gap, 4);
    check("clamp_flag", o_clamp, 1);

    // Valid exactly on the terminal cycle takes effect in the very next period.
    wait_pulse();
    ans_cnt = 3; ans_val = 7; ans_delay = 4;
    wait_pulse();
    check("gap_before_bypass", last_gap, 4);
    wait_pulse();
    check("gap_bypass", last_gap, 7);

    // Unsolicited valid is ignored.
    wait_pulse();
    repeat (5) step();
    vld = 1; ratio = 8'd12;
    step();
    wait_pulse();
    wait_pulse();
    check("gap_spurious", last_gap, 7);

    // Disable mid-period, then re-enable.
    wait_pulse();
    repeat (2) step();
    en = 0;
    step();
    check("dis_clk", o_div_clk, 0);
    check("dis_pulse", o_div_pulse, 0);
    repeat (3) step();
    en = 1;
    step();
    check("reen_pulse", o_div_pulse, 1);
    wait_pulse();
    check("gap_reen", last_gap, 7);

    // Reset mid-period restores the default ratio.
    ans_val = 10; ans_delay = 2;
    repeat (30) step();
    wait_pulse();
    repeat (3) step();
    rst_n = 0;
    step();
    check("rst_mid_clk", o_div_clk, 0);
    check("rst_mid_req", o_ratio_req, 0);
    check("rst_mid_flags", {o_underrun, o_clamp}, 0);
    rst_n = 1; ans_mode = 0;
    step();
    wait_pulse();
    check("gap_after_reset", last_gap, 16);

    // Randomized traffic.
    ans_mode = 3; spur_pct = 3; clr_pct = 2;
    for (int i = 0; i < 4000; i++) begin
      if (i % 60 == 0) ans_delay = int'($urandom_range(1, 12));
      if ($urandom_range(0, 399) == 0) en = ~en;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
